// File: rtl/rotl_pipe_if.sv
// Handshake bundle for rotl_pipe: input word/amount channel plus result channel.
// ROTL_PIPE_DIR_EN adds the in_dir signal to the input channel.
interface rotl_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AW = 5;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
`ifdef ROTL_PIPE_DIR_EN
    logic             in_dir;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

`ifdef ROTL_PIPE_DIR_EN
    modport master (output in_valid, in_data, in_amt, in_dir, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_amt, in_dir, out_ready,
                    output in_ready, out_valid, out_data);
`else
    modport master (output in_valid, in_data, in_amt, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_amt, out_ready,
                    output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/rotl_pipe.sv
// Five-stage logarithmic 32-bit left rotator; stage k rotates by 2^k, whole pipe stalls on backpressure.
// ROTL_PIPE_DIR_EN adds in_dir (1 = rotate right, realised as a left rotate by the negated amount).
module rotl_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    rotl_pipe_if.slave  bus
);
    localparam int unsigned AW   = 5;
    localparam int unsigned NSTG = 5;

    logic             stall;
    logic [AW-1:0]    eff_amt;
    logic             last_v;
    logic [WIDTH-1:0] last_d;

    assign stall         = last_v & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = last_v;
    assign bus.out_data  = last_d;

`ifdef ROTL_PIPE_DIR_EN
    // Right rotate by n == left rotate by (32 - n) mod 32, i.e. the 5-bit negate.
    assign eff_amt = bus.in_dir ? AW'(~bus.in_amt + AW'(1)) : bus.in_amt;
`else
    assign eff_amt = bus.in_amt;
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int unsigned SH = 1 << k;

        logic             v_q;
        logic [WIDTH-1:0] d_q;
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic [AW-1-k:0]  src_amt;

        if (k == 0) begin : g_head
            assign src_v   = bus.in_valid & ~stall;
            assign src_d   = bus.in_data;
            assign src_amt = eff_amt;
        end else begin : g_link
            assign src_v   = g_stg[k-1].v_q;
            assign src_d   = g_stg[k-1].d_q;
            assign src_amt = g_stg[k-1].g_amt.amt_q;
        end

        // Bit 0 of the remaining amount selects this stage's fixed rotate.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (!stall) begin
                v_q <= src_v;
                d_q <= src_amt[0] ? {src_d[WIDTH-1-SH:0], src_d[WIDTH-1:WIDTH-SH]} : src_d;
            end
        end

        // Only the amount bits still needed downstream are carried forward.
        if (k < NSTG - 1) begin : g_amt
            logic [AW-2-k:0] amt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                end else if (!stall) begin
                    amt_q <= src_amt[AW-1-k:1];
                end
            end
        end

        if (k == NSTG - 1) begin : g_tail
            assign last_v = v_q;
            assign last_d = d_q;
        end
    end
endmodule

// File: tb/tb_rotl_pipe.sv
// Self-checking bench for rotl_pipe: directed vectors, streaming, backpressure,
// mid-flight reset and randomized traffic against a queue-based reference model.
module tb_rotl_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    rotl_pipe_if #(.WIDTH(32)) bus ();

    rotl_pipe #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        dir;
        logic [31:0] exp;
    } vec_t;

    exp_t q[$];

    function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] amt, input logic dir);
        int n;
        n = int'(amt);
        if (dir) n = (32 - n) % 32;
        return rotl_ref(x, n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic cur_dir();
`ifdef ROTL_PIPE_DIR_EN
        return bus.in_dir;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: scoreboard bookkeeping before the edge, output checks #1 after it.
    task automatic step();
        logic acc;
        logic was_rst;
        #1;
        was_rst = rst;
        acc = !rst && bus.in_valid && bus.in_ready;
        if (!rst && bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back('{exp: model(bus.in_data, bus.in_amt, cur_dir()), acc: cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) q.delete();
        if (q.size() == 0) begin
            if (bus.out_valid !== 1'b0) chk("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else if (bus.out_valid === 1'b1) begin
            chk("out_data", bus.out_data, q[0].exp);
            if (cyc < q[0].acc + 5) chk("early_result", 32'(cyc - q[0].acc), 32'd5);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_amt   = '0;
`ifdef ROTL_PIPE_DIR_EN
        bus.in_dir   = 1'b0;
`endif
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic dir);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
`ifdef ROTL_PIPE_DIR_EN
        bus.in_dir   = dir;
`else
        if (dir) $display("direction ignored in left-only build");
`endif
    endtask

    // Single word with out_ready high: result must show exactly 5 cycles after accept.
    task automatic send_one(input string name, input vec_t v);
        bus.out_ready = 1'b1;
        drive(v.data, v.amt, v.dir);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        chk({name, "_not_yet"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_data"}, bus.out_data, v.exp);
        step();
    endtask

    initial begin
        vec_t vecs[8];
        int   nvec;
        int   sent;
        int   accepted;
        int   guard;
        logic [31:0] held;

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.out_ready = 1'b0;
        idle_inputs();

        vecs[0] = '{data: 32'h0000_0001, amt: 5'd11, dir: 1'b0, exp: 32'h0000_0800};
        vecs[1] = '{data: 32'h8000_0000, amt: 5'd1,  dir: 1'b0, exp: 32'h0000_0001};
        vecs[2] = '{data: 32'hDEAD_BEEF, amt: 5'd0,  dir: 1'b0, exp: 32'hDEAD_BEEF};
        vecs[3] = '{data: 32'hCF02_468A, amt: 5'd11, dir: 1'b0, exp: 32'h1234_5678};
        vecs[4] = '{data: 32'hFFFF_0000, amt: 5'd31, dir: 1'b0, exp: 32'h7FFF_8000};
        nvec = 5;
`ifdef ROTL_PIPE_DIR_EN
        vecs[5] = '{data: 32'h0000_0800, amt: 5'd11, dir: 1'b1, exp: 32'h0000_0001};
        vecs[6] = '{data: 32'hDEAD_BEEF, amt: 5'd0,  dir: 1'b1, exp: 32'hDEAD_BEEF};
        vecs[7] = '{data: 32'h1234_5678, amt: 5'd11, dir: 1'b1, exp: 32'hCF02_468A};
        nvec = 8;
`endif

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < nvec; i++) send_one($sformatf("vec%0d", i), vecs[i]);

        // Streaming: 32 back-to-back words
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                drive(32'hA5A5_0000 + 32'(i), 5'(i), 1'b0);
                #1;
                chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                idle_inputs();
            end
            chk("stream_out_valid", 32'(bus.out_valid), 32'((i >= 5) && (i < 37)));
            step();
        end

        // Backpressure: 8 words offered against a blocked output
        bus.out_ready = 1'b0;
        sent = 0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h0BAD_0000 + 32'(sent), 5'(3 * sent + 1), 1'b0);
            #1;
            if (i >= 5) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            if (bus.in_ready) begin
                sent++;
                accepted++;
            end
            step();
        end
        chk("bp_accepted", 32'(accepted), 32'd5);
        held = bus.out_data;
        chk("bp_first_result", held, model(32'h0BAD_0000, 5'd1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", bus.out_data, held);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
        while (sent < 8) begin
            drive(32'h0BAD_0000 + 32'(sent), 5'(3 * sent + 1), 1'b0);
            sent++;
            step();
        end
        idle_inputs();
        guard = 0;
        while (q.size() > 0 && guard < 30) begin
            step();
            guard++;
        end
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Reset mid-flight discards three in-flight words
        for (int i = 0; i < 3; i++) begin
            drive(32'h5EED_0000 + 32'(i), 5'(i + 4), 1'b0);
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", bus.out_data, 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_rst_no_emit", 32'(bus.out_valid), 32'd0);
        end
        send_one("post_rst", '{data: 32'h0000_0003, amt: 5'd30, dir: 1'b0, exp: 32'hC000_0000});

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) drive($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else idle_inputs();
`ifndef ROTL_PIPE_DIR_EN
            if (bus.in_valid) bus.in_amt = 5'($urandom_range(0, 31));
`endif
            step();
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 30) begin
            step();
            guard++;
        end
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
